// File: rtl/vending_controller.sv
// Coin-credit vending controller: collects coins, vends a product with a timed
// motor pulse, tracks per-product stock and pays change back one coin per cycle.
module vending_controller #(
  parameter int                         NUM_PRODUCTS = 4,
  parameter int                         W            = 8,
  parameter int                         MAX_CREDIT   = 95,
  parameter logic [NUM_PRODUCTS*W-1:0]  PRICES       = {8'd30, 8'd25, 8'd20, 8'd15},
  parameter int                         STOCK_W      = 4,
  parameter int                         STOCK_INIT   = 3,
  parameter int                         VEND_CYCLES  = 4,
  localparam int                        SEL_W        = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
  input  logic                    clock,
  input  logic                    clear_n,
  input  logic                    coin_valid,
  input  logic [1:0]              coin,
  input  logic                    select_valid,
  input  logic [SEL_W-1:0]        select,
  input  logic                    cancel,
  input  logic                    restock,
  output logic [W-1:0]            credit,
  output logic                    vend_valid,
  output logic [SEL_W-1:0]        vend_product,
  output logic                    change_valid,
  output logic [1:0]              change_coin,
  output logic                    coin_reject,
  output logic                    deny,
  output logic [NUM_PRODUCTS-1:0] sold_out,
  output logic                    busy
);

  localparam int CW    = W + 1;
  localparam int CNT_W = (VEND_CYCLES > 1) ? $clog2(VEND_CYCLES) : 1;

  typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

  state_t            state_reg, state_next;
  logic [W-1:0]      credit_reg, credit_next;
  logic [CNT_W-1:0]  vend_cnt_reg, vend_cnt_next;
  logic [SEL_W-1:0]  vend_product_reg, vend_product_next;
  logic              vend_valid_reg, change_valid_reg, coin_reject_reg, deny_reg, busy_reg;
  logic [1:0]        change_coin_reg;
  logic              coin_reject_next, deny_next, sale;

  logic [CW-1:0]     coin_value, coin_sum, price_sel;
  logic              select_hit, select_stocked;
  logic [NUM_PRODUCTS-1:0] stock_zero;

  // Greedy change: largest coin that still fits in the remaining credit.
  function automatic logic [1:0] greedy_code(input logic [W-1:0] c);
    if (32'(c) >= 25)      return 2'b10;
    else if (32'(c) >= 10) return 2'b01;
    else                   return 2'b00;
  endfunction

  function automatic logic [W-1:0] code_value(input logic [1:0] code);
    case (code)
      2'b10:   return W'(25);
      2'b01:   return W'(10);
      default: return W'(5);
    endcase
  endfunction

  always_comb begin
    case (coin)
      2'b00:   coin_value = CW'(5);
      2'b01:   coin_value = CW'(10);
      2'b10:   coin_value = CW'(25);
      default: coin_value = '0;
    endcase
    coin_sum = {1'b0, credit_reg} + coin_value;
  end

  always_comb begin
    price_sel      = '0;
    select_hit     = 1'b0;
    select_stocked = 1'b0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (select == SEL_W'(i)) begin
        price_sel      = {1'b0, PRICES[i*W +: W]};
        select_hit     = 1'b1;
        select_stocked = !stock_zero[i];
      end
    end
  end

  always_comb begin
    state_next        = state_reg;
    credit_next       = credit_reg;
    vend_cnt_next     = vend_cnt_reg;
    vend_product_next = vend_product_reg;
    coin_reject_next  = 1'b0;
    deny_next         = 1'b0;
    sale              = 1'b0;
    case (state_reg)
      COLLECT: begin
        if (cancel && credit_reg != '0) begin
          state_next       = CHANGE;
          coin_reject_next = coin_valid;
        end else if (select_valid) begin
          // A coin coinciding with any selection outcome is handed back.
          coin_reject_next = coin_valid;
          if (select_hit && select_stocked && {1'b0, credit_reg} >= price_sel) begin
            sale              = 1'b1;
            credit_next       = credit_reg - price_sel[W-1:0];
            vend_product_next = select;
            vend_cnt_next     = CNT_W'(VEND_CYCLES - 1);
            state_next        = VEND;
          end else begin
            deny_next = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin != 2'b11 && coin_sum <= CW'(MAX_CREDIT)) credit_next = coin_sum[W-1:0];
          else coin_reject_next = 1'b1;
        end
      end
      VEND: begin
        coin_reject_next = coin_valid;
        if (vend_cnt_reg == '0) state_next = (credit_reg != '0) ? CHANGE : COLLECT;
        else vend_cnt_next = vend_cnt_reg - CNT_W'(1);
      end
      CHANGE: begin
        coin_reject_next = coin_valid;
        credit_next      = credit_reg - code_value(greedy_code(credit_reg));
        if (credit_next == '0) state_next = COLLECT;
      end
      default: state_next = COLLECT;
    endcase
  end

  // Outputs are registered copies of the next state, so they line up with it.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_reg        <= COLLECT;
      credit_reg       <= '0;
      vend_cnt_reg     <= '0;
      vend_product_reg <= '0;
      vend_valid_reg   <= 1'b0;
      change_valid_reg <= 1'b0;
      change_coin_reg  <= 2'b00;
      coin_reject_reg  <= 1'b0;
      deny_reg         <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      credit_reg       <= credit_next;
      vend_cnt_reg     <= vend_cnt_next;
      vend_product_reg <= vend_product_next;
      vend_valid_reg   <= (state_next == VEND);
      change_valid_reg <= (state_next == CHANGE);
      if (state_next == CHANGE) change_coin_reg <= greedy_code(credit_next);
      coin_reject_reg  <= coin_reject_next;
      deny_reg         <= deny_next;
      busy_reg         <= (state_next != COLLECT);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PRODUCTS; gi++) begin : g_stock
      logic [STOCK_W-1:0] count_reg, count_next;
      logic               empty_reg;

      always_comb begin
        count_next = count_reg;
        if (restock) count_next = STOCK_W'(STOCK_INIT);
        else if (sale && select == SEL_W'(gi) && count_reg != '0) count_next = count_reg - STOCK_W'(1);
      end

      always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
          count_reg <= STOCK_W'(STOCK_INIT);
          empty_reg <= (STOCK_INIT == 0);
        end else begin
          count_reg <= count_next;
          empty_reg <= (count_next == '0);
        end
      end

      assign stock_zero[gi] = (count_reg == '0);
      assign sold_out[gi]   = empty_reg;
    end
  endgenerate

  assign credit       = credit_reg;
  assign vend_valid   = vend_valid_reg;
  assign vend_product = vend_product_reg;
  assign change_valid = change_valid_reg;
  assign change_coin  = change_coin_reg;
  assign coin_reject  = coin_reject_reg;
  assign deny         = deny_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_vending_controller.sv
// Bench for vending_controller: scenario tasks with inline checks, plus a
// scoreboard of expected change coins consumed whenever the DUT ejects one.
module tb_vending_controller;

  logic       clock = 1'b0;
  logic       clear_n = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       select_valid = 1'b0;
  logic [1:0] select = 2'b00;
  logic       cancel = 1'b0;
  logic       restock = 1'b0;

  logic [7:0] credit;
  logic       vend_valid;
  logic [1:0] vend_product;
  logic       change_valid;
  logic [1:0] change_coin;
  logic       coin_reject;
  logic       deny;
  logic [3:0] sold_out;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_change_q[$];
  logic [1:0] exp_coin;

  vending_controller dut (
    .clock(clock), .clear_n(clear_n), .coin_valid(coin_valid), .coin(coin),
    .select_valid(select_valid), .select(select), .cancel(cancel), .restock(restock),
    .credit(credit), .vend_valid(vend_valid), .vend_product(vend_product),
    .change_valid(change_valid), .change_coin(change_coin), .coin_reject(coin_reject),
    .deny(deny), .sold_out(sold_out), .busy(busy)
  );

  always #5 clock = ~clock;

  // Scoreboard consumer: every ejected coin must be the next expected one.
  always @(negedge clock) begin
    if (clear_n && change_valid) begin
      checks++;
      if (exp_change_q.size() == 0) begin
        errors++;
        $display("FAIL change_unexpected got coin %b expected none", change_coin);
      end else begin
        exp_coin = exp_change_q.pop_front();
        if (change_coin !== exp_coin) begin
          errors++;
          $display("FAIL change_coin got %b expected %b", change_coin, exp_coin);
        end else begin
          $display("change coin %b ok", change_coin);
        end
      end
    end
  end

  // Stimulus: apply strobes at a falling edge, hold one cycle, release.
  task automatic drive(input logic cv, input logic [1:0] c, input logic sv,
                       input logic [1:0] s, input logic cn, input logic rs);
    coin_valid = cv; coin = c; select_valid = sv; select = s; cancel = cn; restock = rs;
    @(negedge clock);
    coin_valid = 1'b0; select_valid = 1'b0; cancel = 1'b0; restock = 1'b0;
  endtask

  task automatic put_coin(input logic [1:0] c);
    drive(1'b1, c, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic push_change(input int amount);
    int left;
    left = amount;
    while (left > 0) begin
      if (left >= 25)      begin exp_change_q.push_back(2'b10); left -= 25; end
      else if (left >= 10) begin exp_change_q.push_back(2'b01); left -= 10; end
      else                 begin exp_change_q.push_back(2'b00); left -= 5;  end
    end
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 64; i++) begin
      if (!busy) break;
      @(negedge clock);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout busy %b expected 0", busy);
    end
  endtask

  task automatic test_reset;
    #2;
    checks++; if (credit !== 8'd0) begin errors++; $display("FAIL reset_credit got %0d expected 0", credit); end
    checks++; if ({vend_valid, change_valid, coin_reject, deny, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b expected 00000", {vend_valid, change_valid, coin_reject, deny, busy});
    end
    checks++; if ({vend_product, change_coin} !== 4'b0) begin
      errors++; $display("FAIL reset_product_coin got %b expected 0000", {vend_product, change_coin});
    end
    checks++; if (sold_out !== 4'b0000) begin errors++; $display("FAIL reset_sold_out got %b expected 0000", sold_out); end
    @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);
    $display("reset released credit %0d busy %b", credit, busy);
  endtask

  task automatic test_sale;
    int vcnt;
    put_coin(2'b10);
    checks++; if (credit !== 8'd25 || coin_reject !== 1'b0) begin
      errors++; $display("FAIL sale_quarter credit %0d rej %b expected 25 0", credit, coin_reject);
    end
    put_coin(2'b01);
    checks++; if (credit !== 8'd35) begin errors++; $display("FAIL sale_dime credit %0d expected 35", credit); end
    push_change(20);
    drive(1'b0, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0);
    checks++; if (credit !== 8'd20 || vend_valid !== 1'b1 || vend_product !== 2'd0 || busy !== 1'b1 || deny !== 1'b0) begin
      errors++; $display("FAIL sale_select credit %0d vend %b prod %0d busy %b deny %b expected 20 1 0 1 0",
                         credit, vend_valid, vend_product, busy, deny);
    end
    vcnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (vend_valid) vcnt++;
      else break;
    end
    checks++; if (vcnt !== 4) begin errors++; $display("FAIL sale_vend_len got %0d expected 4", vcnt); end
    checks++; if (change_valid !== 1'b1) begin errors++; $display("FAIL sale_change_start got %b expected 1", change_valid); end
    wait_idle;
    checks++; if (credit !== 8'd0) begin errors++; $display("FAIL sale_end_credit got %0d expected 0", credit); end
    $display("sale done credit %0d", credit);
  endtask

  task automatic test_credit_limit;
    for (int k = 0; k < 3; k++) begin
      put_coin(2'b10);
      checks++; if (credit !== 8'(25 * (k + 1)) || coin_reject !== 1'b0) begin
        errors++; $display("FAIL limit_accept%0d credit %0d rej %b expected %0d 0", k, credit, coin_reject, 25 * (k + 1));
      end
    end
    put_coin(2'b10);
    checks++; if (credit !== 8'd75 || coin_reject !== 1'b1) begin
      errors++; $display("FAIL limit_over credit %0d rej %b expected 75 1", credit, coin_reject);
    end
    put_coin(2'b11);
    checks++; if (credit !== 8'd75 || coin_reject !== 1'b1) begin
      errors++; $display("FAIL limit_invalid credit %0d rej %b expected 75 1", credit, coin_reject);
    end
    push_change(75);
    drive(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
    wait_idle;
    $display("credit limit done credit %0d", credit);
  endtask

  task automatic test_deny_sold_out;
    put_coin(2'b01);
    drive(1'b0, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0);
    checks++; if (deny !== 1'b1 || credit !== 8'd10 || vend_valid !== 1'b0) begin
      errors++; $display("FAIL deny_credit deny %b credit %0d vend %b expected 1 10 0", deny, credit, vend_valid);
    end
    push_change(10);
    drive(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
    wait_idle;
    for (int k = 0; k < 3; k++) begin
      put_coin(2'b10);
      put_coin(2'b00);
      drive(1'b0, 2'b00, 1'b1, 2'd3, 1'b0, 1'b0);
      checks++; if (vend_valid !== 1'b1 || credit !== 8'd0 || vend_product !== 2'd3) begin
        errors++; $display("FAIL buy3_%0d vend %b credit %0d prod %0d expected 1 0 3", k, vend_valid, credit, vend_product);
      end
      wait_idle;
    end
    checks++; if (sold_out !== 4'b1000) begin errors++; $display("FAIL sold_out got %b expected 1000", sold_out); end
    put_coin(2'b10);
    put_coin(2'b00);
    drive(1'b0, 2'b00, 1'b1, 2'd3, 1'b0, 1'b0);
    checks++; if (deny !== 1'b1 || credit !== 8'd30 || busy !== 1'b0) begin
      errors++; $display("FAIL deny_sold_out deny %b credit %0d busy %b expected 1 30 0", deny, credit, busy);
    end
    drive(1'b0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1);
    checks++; if (sold_out !== 4'b0000) begin errors++; $display("FAIL restock got %b expected 0000", sold_out); end
    push_change(30);
    drive(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
    wait_idle;
    $display("deny/sold-out done sold_out %b", sold_out);
  endtask

  task automatic test_cancel;
    put_coin(2'b10);
    put_coin(2'b01);
    put_coin(2'b00);
    checks++; if (credit !== 8'd40) begin errors++; $display("FAIL cancel_setup credit %0d expected 40", credit); end
    push_change(40);
    drive(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
    checks++; if (change_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL cancel_start change %b busy %b expected 1 1", change_valid, busy);
    end
    wait_idle;
    checks++; if (credit !== 8'd0) begin errors++; $display("FAIL cancel_end credit %0d expected 0", credit); end
    drive(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
    checks++; if (busy !== 1'b0 || change_valid !== 1'b0 || credit !== 8'd0) begin
      errors++; $display("FAIL cancel_zero busy %b change %b credit %0d expected 0 0 0", busy, change_valid, credit);
    end
    $display("cancel done credit %0d", credit);
  endtask

  task automatic test_simultaneous;
    put_coin(2'b01);
    put_coin(2'b01);
    drive(1'b1, 2'b01, 1'b1, 2'd1, 1'b0, 1'b0);
    checks++; if (coin_reject !== 1'b1 || credit !== 8'd0 || vend_valid !== 1'b1 || vend_product !== 2'd1) begin
      errors++; $display("FAIL sim_select rej %b credit %0d vend %b prod %0d expected 1 0 1 1",
                         coin_reject, credit, vend_valid, vend_product);
    end
    wait_idle;
    put_coin(2'b10);
    put_coin(2'b01);
    put_coin(2'b00);
    push_change(40);
    drive(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
    put_coin(2'b10);
    checks++; if (coin_reject !== 1'b1 || change_valid !== 1'b1) begin
      errors++; $display("FAIL busy_coin rej %b change %b expected 1 1", coin_reject, change_valid);
    end
    wait_idle;
    checks++; if (credit !== 8'd0) begin errors++; $display("FAIL busy_coin_credit got %0d expected 0", credit); end
    $display("simultaneous done credit %0d", credit);
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 3; k++) begin
      put_coin(2'b10);
      put_coin(2'b00);
      drive(1'b0, 2'b00, 1'b1, 2'd3, 1'b0, 1'b0);
      wait_idle;
    end
    checks++; if (sold_out !== 4'b1000) begin errors++; $display("FAIL mid_sold_out got %b expected 1000", sold_out); end
    put_coin(2'b10);
    put_coin(2'b01);
    put_coin(2'b00);
    push_change(40);
    drive(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
    @(negedge clock);
    #2 clear_n = 1'b0;
    #1;
    checks++; if (credit !== 8'd0 || change_valid !== 1'b0 || busy !== 1'b0 || vend_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset credit %0d change %b busy %b vend %b expected 0 0 0 0",
                         credit, change_valid, busy, vend_valid);
    end
    checks++; if (sold_out !== 4'b0000) begin errors++; $display("FAIL mid_reset_stock got %b expected 0000", sold_out); end
    exp_change_q.delete();
    @(negedge clock);
    #1 clear_n = 1'b1;
    @(negedge clock);
    put_coin(2'b01);
    checks++; if (credit !== 8'd10 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_resume credit %0d busy %b expected 10 0", credit, busy);
    end
    push_change(10);
    drive(1'b0, 2'b00, 1'b0, 2'd0, 1'b1, 1'b0);
    wait_idle;
    $display("reset mid-change done credit %0d", credit);
  endtask

  initial begin
    test_reset;
    test_sale;
    test_credit_limit;
    test_deny_sold_out;
    test_cancel;
    test_simultaneous;
    test_reset_mid;
    checks++;
    if (exp_change_q.size() != 0) begin
      errors++; $display("FAIL change_pending got %0d coins expected 0", exp_change_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vending_controller.md
# vending_controller

Parametrised vending-machine controller: the next generation of the coin-credit FSM in the lab vending design. It generalises product count, prices, credit width and stock, and adds over-limit coin rejection, per-product inventory with sold-out flags, a timed vend pulse and coin-by-coin change dispensing. It sits between the upstream button edge detectors and the downstream display/motor drivers; all inputs are single-cycle strobes already synchronised to `clock`.

## Interface
- `NUM_PRODUCTS`, default 4: number of selectable products, ≥1.
- `W`, default 8: credit/price width in bits, unsigned binary cents.
- `MAX_CREDIT`, default 95: highest credit accepted; multiple of 5, < 2^W.
- `PRICES`, default {8'd30,8'd25,8'd20,8'd15}: packed `NUM_PRODUCTS*W` bits. Product i is at bits [i*W +: W]. Each price is a nonzero multiple of 5.
- `STOCK_W`, default 4: stock counter width per product.
- `STOCK_INIT`, default 3: stock loaded at reset/restock, < 2^STOCK_W.
- `VEND_CYCLES`, default 4: length of the vend pulse, ≥1.
- `clock` in 1: single clock, rising edge.
- `clear_n` in 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `coin_valid` in 1: coin strobe.
- `coin` in 2: 00 nickel (5), 01 dime (10), 10 quarter (25), 11 invalid.
- `select_valid` in 1: product selection strobe.
- `select` in max(1,$clog2(NUM_PRODUCTS)): product index.
- `cancel` in 1: return-all-credit strobe.
- `restock` in 1: reload every stock counter to `STOCK_INIT`.
- `credit` out W: current credit.
- `vend_valid` out 1: motor drive, high `VEND_CYCLES` cycles per sale.
- `vend_product` out same as `select`: product being vended; holds last value.
- `change_valid` out 1: one change coin ejected this cycle.
- `change_coin` out 2: coin ejected, same encoding as `coin`.
- `coin_reject` out 1: one-cycle pulse, the inserted coin is returned.
- `deny` out 1: one-cycle pulse, selection refused.
- `sold_out` out NUM_PRODUCTS: bit i high when stock[i]==0.
- `busy` out 1: high in VEND or CHANGE.

## Operation
- **States:** COLLECT, VEND, CHANGE.
- **Reset values:**
  - State COLLECT; `credit` = 0; all stock = `STOCK_INIT`.
  - `vend_valid`, `change_valid`, `coin_reject`, `deny`, `busy` = 0.
  - `vend_product` = 0; `change_coin` = 00.
  - `sold_out` reflects `STOCK_INIT`.
- **COLLECT, priority order (at most one action per cycle):**
  - `cancel` first. If credit > 0, go to CHANGE; if credit == 0, no effect.
  - `select_valid` next; the selection is priced against the pre-edge credit. It is denied (`deny` pulse, credit unchanged) if `select` ≥ `NUM_PRODUCTS`, stock == 0, or credit < price.
  - An accepted selection does all of the following at the same edge: credit −= price, stock[select] −= 1, `vend_product` ← select, load the vend counter, go to VEND.
  - `coin_valid` last. Credit += value if coin ≠ 11 and credit+value ≤ `MAX_CREDIT`. Otherwise `coin_reject` pulses and credit is unchanged.
  - A coin arriving in the same cycle as an accepted `cancel` or `select` is rejected (`coin_reject`), never lost.
- **VEND:**
  - `vend_valid` is high for exactly `VEND_CYCLES` cycles.
  - Afterwards, go to CHANGE if credit > 0, else COLLECT.
- **CHANGE:**
  - Each cycle eject the greedy largest coin ≤ credit (25, 10, then 5): `change_valid` = 1, `change_coin` = that coin, credit −= value.
  - The state returns to COLLECT on the edge where credit reaches 0.
- **In VEND/CHANGE:**
  - Every `coin_valid` is answered with `coin_reject`.
  - `select_valid` and `cancel` are ignored; no `deny`.
- **restock:**
  - Honoured in any state.
  - Overrides a coincident stock decrement; the purchase is still vended and charged.
- **Arithmetic:**
  - Credit compare and add use W+1 bits, so no wrap is possible.
  - Stock never decrements below 0.

## Timing
- All outputs are registered; nothing is combinational from inputs to outputs.
- Strobe sampled at edge t → effect visible after edge t. `credit`, `coin_reject`, `deny` and the first `vend_valid` cycle appear in cycle t+1.
- Last vend cycle is t+`VEND_CYCLES`; the first change coin follows in the next cycle.
- Change takes ceil-greedy-count cycles, one coin per cycle, with no gaps.
- `busy` is high from the first VEND/CHANGE cycle up to, but not including, the first COLLECT cycle.
- `clear_n` low at any point, mid-vend or mid-change included: all state and outputs go to reset values immediately, without waiting for a clock edge. Operation resumes on the first edge after release.

## Test plan
- **Normal sale with change:** quarter, dime → credit 35; select 0 (price 15) → credit 20, vend_valid 4 cycles with vend_product 0 → dime, dime on consecutive cycles → credit 0, busy low.
- **Credit limit:** 4 quarters (MAX_CREDIT 95) → first three accepted, credit 75; 4th gives coin_reject with credit still 75. Coin 11 → coin_reject.
- **Deny and sold out:**
  - Credit 10, select 0 → deny, credit 10.
  - Three exact-30 buys of product 3 → sold_out[3] = 1; a 4th with 30 credit → deny.
  - restock → sold_out = 0.
- **Cancel:** credit 40, cancel → quarter, dime, nickel on 3 consecutive cycles, credit 0. Cancel at credit 0 → nothing.
- **Simultaneous and busy inputs:**
  - Credit 20, select 1 and dime in the same cycle → sale charged 20, coin_reject.
  - Coin during CHANGE → coin_reject, change sequence unaltered.
- **Reset mid-operation:** clear_n low during the 2nd change coin → credit 0, change_valid 0, state COLLECT, stock back to STOCK_INIT before the next edge.
